ft601_rx_ctrl: RTL and testbench
================================

# ft601_rx_ctrl

Host-to-FPGA read engine for the FT601 in 245 synchronous FIFO mode. It is the receive counterpart of the transmit controller that pushes local FIFO data out to the host. It watches RXF_N and requests the shared FT601 bus through a req/gnt handshake with the transmit side. It then drives OE_N/RD_N, captures 32-bit words with byte enables, and writes them into a downstream receive FIFO under almost-full backpressure, keeping byte counters and sticky error flags for status LEDs and debug.

## Interface
Parameters:
- MAX_BURST, 256: maximum words captured per bus tenure before the bus is released; legal range 1..4096.

Ports:
- ft601_clk  in  1  FT601-supplied 100 MHz clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  receive enable; sampled only in IDLE.
- RXF_N  in  1  FT601 receive-FIFO-not-empty, active low.
- DATA_IN  in  32  DATA bus input (pad-side tristate owned by top level).
- BE_IN  in  4  BE bus input.
- OE_N  out  1  FT601 data output enable, active low, registered.
- RD_N  out  1  FT601 read enable, active low, registered.
- bus_req  out  1  request for FT601 bus ownership.
- bus_gnt  in  1  grant from arbiter; transmit side never drives DATA/BE while bus_req & bus_gnt.
- fifo_wr_data  out  32  captured word.
- fifo_wr_be  out  4  captured byte enables.
- fifo_wr_en  out  1  one-cycle write strobe per captured word.
- fifo_almost_full  in  1  downstream FIFO has ≤2 free entries.
- fifo_full  in  1  downstream FIFO full.
- err_clr  in  1  synchronous clear of be_err and ovf_err.
- rx_byte_cnt  out  32  total valid bytes received; wraps modulo 2^32.
- be_err  out  1  sticky: illegal BE pattern captured.
- ovf_err  out  1  sticky: write attempted while fifo_full.

## Operation
- States: IDLE, REQ, OE, READ, TURN.
- IDLE: OE_N=1, RD_N=1, bus_req=0.
  - Go to REQ when en & ~RXF_N & ~fifo_almost_full.
- REQ: bus_req=1.
  - If RXF_N=1, return to IDLE and drop bus_req.
  - Otherwise, on bus_gnt, go to OE.
- OE: OE_N=0 for exactly one cycle (bus turnaround), RD_N=1, then READ.
- READ: OE_N=0, RD_N=0.
  - A word is captured on every edge in READ where RXF_N=0.
  - Leave for TURN on the edge where any of these holds:
    - RXF_N=1;
    - fifo_almost_full=1;
    - the beat counter reaches MAX_BURST captured words.
  - A word present on that exit edge is still captured.
- TURN: OE_N=1, RD_N=1, bus_req=1 for one cycle, then IDLE with bus_req=0.
- Beat counter: $clog2(MAX_BURST+1) bits, cleared on entry to OE, +1 per captured word.
- Legal BE values are 4'b1111, 0111, 0011 and 0001.
  - rx_byte_cnt adds the popcount of BE_IN per captured word.
  - An illegal BE is still written, adds its popcount, and sets be_err.
- If fifo_full=1 on the cycle fifo_wr_en would assert, the word is dropped: no fifo_wr_en, ovf_err set, rx_byte_cnt unchanged.
- Error flags: err_clr clears both. If a set event occurs in the same cycle as err_clr, set wins.
- If bus_gnt drops during OE/READ, the burst continues. Releasing the bus is the arbiter's responsibility only after bus_req falls.

## Timing
- Reset values:
  - OE_N=1, RD_N=1, bus_req=0;
  - fifo_wr_en=0, fifo_wr_data=0, fifo_wr_be=0;
  - rx_byte_cnt=0, be_err=0, ovf_err=0;
  - state IDLE.
- Reset asserted mid-burst forces all of the above immediately (asynchronous). OE_N and RD_N go high without a TURN cycle.
- Capture latency: DATA_IN/BE_IN sampled at edge N appear on fifo_wr_data/fifo_wr_be with fifo_wr_en=1 after edge N (one register stage). rx_byte_cnt updates on the same edge as fifo_wr_en.
- Minimum tenure: RXF_N low with bus_gnt already high → bus_req rises at edge 1, OE_N falls at edge 2, RD_N falls at edge 3, first capture at edge 4.
- Backpressure margin: at most one capture follows the edge where fifo_almost_full is seen high. Hence the ≥2-entry almost_full threshold.
- Consecutive bursts: at least one IDLE cycle between TURN and the next REQ.

## Test plan
- Basic burst: gnt tied 1, RXF_N low for 4 cycles from READ entry, DATA 0x11111111..0x44444444, BE=F → 4 fifo_wr_en pulses in order; rx_byte_cnt=16; OE_N/RD_N high after TURN; bus_req low in IDLE.
- Short word: last word BE=4'b0011 → rx_byte_cnt=14, be_err=0. Then BE=4'b0101 → be_err=1, cleared by err_clr.
- Backpressure: RXF_N held low, fifo_almost_full asserted after 3rd capture → exactly 4 words written, TURN, no REQ until almost_full deasserts.
- Burst limit: MAX_BURST=8, RXF_N low 20 cycles → 8 words, TURN, IDLE, re-request; second tenure captures remaining words; rx_byte_cnt=80.
- Grant wait: RXF_N low, gnt held 0 for 5 cycles → OE_N stays 1, bus_req stays 1; RXF_N rises before grant → back to IDLE, no writes.
- Overflow and reset: fifo_full forced high during capture → word dropped, ovf_err=1. reset_n pulsed mid-READ → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ft601_rx_ctrl_if.sv
// ft601_rx_ctrl_if
// Bundles the signals exchanged between the FT601 receive controller and its
// surroundings: the FT601 245-mode read pins, the bus arbiter handshake and
// the downstream receive FIFO write port.
//
// Signals (direction as seen from the controller, i.e. the master modport):
//   RXF_N            in   FT601 receive FIFO not empty, active low
//   DATA_IN[31:0]    in   FT601 DATA bus input
//   BE_IN[3:0]       in   FT601 BE bus input
//   OE_N             out  FT601 data output enable, active low
//   RD_N             out  FT601 read enable, active low
//   bus_req          out  FT601 bus ownership request
//   bus_gnt          in   FT601 bus ownership grant
//   fifo_wr_data     out  captured word
//   fifo_wr_be       out  captured byte enables
//   fifo_wr_en       out  one-cycle write strobe per accepted word
//   fifo_almost_full in   downstream FIFO has two or fewer free entries
//   fifo_full        in   downstream FIFO full
interface ft601_rx_ctrl_if;
  logic        RXF_N;
  logic [31:0] DATA_IN;
  logic [3:0]  BE_IN;
  logic        OE_N;
  logic        RD_N;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] fifo_wr_data;
  logic [3:0]  fifo_wr_be;
  logic        fifo_wr_en;
  logic        fifo_almost_full;
  logic        fifo_full;

  modport master (
    input  RXF_N, DATA_IN, BE_IN, bus_gnt, fifo_almost_full, fifo_full,
    output OE_N, RD_N, bus_req, fifo_wr_data, fifo_wr_be, fifo_wr_en
  );

  modport slave (
    output RXF_N, DATA_IN, BE_IN, bus_gnt, fifo_almost_full, fifo_full,
    input  OE_N, RD_N, bus_req, fifo_wr_data, fifo_wr_be, fifo_wr_en
  );
endinterface

// File: rtl/ft601_rx_ctrl.sv
// ft601_rx_ctrl
// Host-to-FPGA read engine for the FT601 in 245 synchronous FIFO mode.
// Requests the shared FT601 bus from the arbiter, performs the OE_N/RD_N read
// sequence, captures 32-bit words with byte enables and pushes them into a
// downstream FIFO under almost-full backpressure.
//
// Ports:
//   ft601_clk    in   FT601-supplied clock, all logic on its rising edge
//   reset_n      in   asynchronous active-low reset
//   en           in   receive enable, only looked at while idle
//   err_clr      in   synchronous clear of be_err / ovf_err (set wins)
//   bus          ---  ft601_rx_ctrl_if.master: FT601 pins, arbiter, FIFO port
//   rx_byte_cnt  out  total valid bytes written, wraps modulo 2^32
//   be_err       out  sticky: a word with an illegal BE pattern was captured
//   ovf_err      out  sticky: a word was captured while the FIFO was full
module ft601_rx_ctrl #(
  parameter int MAX_BURST = 256
) (
  input  logic                   ft601_clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   err_clr,
  ft601_rx_ctrl_if.master        bus,
  output logic [31:0]            rx_byte_cnt,
  output logic                   be_err,
  output logic                   ovf_err
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    OE,
    READ,
    TURN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BEAT_W-1:0] beat_cnt;
  logic              capture;
  logic              burst_done;
  logic              be_legal;
  logic              oe_n_next;
  logic              rd_n_next;
  logic              req_next;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // A word is on the bus on every READ edge where the FT601 still has data.
  assign capture    = (state == READ) && !bus.RXF_N;
  // The capture happening now is the last one allowed in this tenure.
  assign burst_done = capture && (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign be_legal   = (bus.BE_IN == 4'b1111) || (bus.BE_IN == 4'b0111) ||
                      (bus.BE_IN == 4'b0011) || (bus.BE_IN == 4'b0001);

  // Next state plus the pin levels belonging to that state; the pins are
  // registered from this decode so they change cleanly on the clock edge.
  always_comb begin
    state_next = state;
    oe_n_next  = 1'b1;
    rd_n_next  = 1'b1;
    req_next   = 1'b0;
    case (state)
      IDLE: if (en && !bus.RXF_N && !bus.fifo_almost_full) state_next = REQ;
      REQ: begin
        if (bus.RXF_N)        state_next = IDLE;
        else if (bus.bus_gnt) state_next = OE;
      end
      OE:   state_next = READ;
      READ: if (bus.RXF_N || bus.fifo_almost_full || burst_done) state_next = TURN;
      TURN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    case (state_next)
      REQ:  req_next = 1'b1;
      OE: begin
        req_next  = 1'b1;
        oe_n_next = 1'b0;
      end
      READ: begin
        req_next  = 1'b1;
        oe_n_next = 1'b0;
        rd_n_next = 1'b0;
      end
      TURN: req_next = 1'b1;
      default: req_next = 1'b0;
    endcase
  end

  always_ff @(posedge ft601_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bus.OE_N    <= 1'b1;
      bus.RD_N    <= 1'b1;
      bus.bus_req <= 1'b0;
    end else begin
      state       <= state_next;
      bus.OE_N    <= oe_n_next;
      bus.RD_N    <= rd_n_next;
      bus.bus_req <= req_next;
    end
  end

  always_ff @(posedge ft601_clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt         <= '0;
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_wr_data <= '0;
      bus.fifo_wr_be   <= '0;
      rx_byte_cnt      <= '0;
      be_err           <= 1'b0;
      ovf_err          <= 1'b0;
    end else begin
      if (state_next == OE)
        beat_cnt <= '0;
      else if (capture)
        beat_cnt <= beat_cnt + BEAT_W'(1);

      // A word captured while the FIFO is full is dropped entirely: no
      // strobe and no byte count, only the sticky overflow flag.
      bus.fifo_wr_en <= capture && !bus.fifo_full;
      if (capture && !bus.fifo_full) begin
        bus.fifo_wr_data <= bus.DATA_IN;
        bus.fifo_wr_be   <= bus.BE_IN;
        rx_byte_cnt      <= rx_byte_cnt + {29'd0, popcount4(bus.BE_IN)};
      end

      // Clear first, then OR in a same-cycle set so the set wins.
      be_err  <= (be_err  && !err_clr) || (capture && !be_legal);
      ovf_err <= (ovf_err && !err_clr) || (capture && bus.fifo_full);
    end
  end

endmodule

// File: tb/tb_ft601_rx_ctrl.sv
// tb_ft601_rx_ctrl
// Self-checking bench for ft601_rx_ctrl. A procedural tenure model predicts
// every output each cycle; directed scenarios pin the model with literal
// expectations, then a randomized phase exercises arbitrary input mixes.
module tb_ft601_rx_ctrl;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] rx_byte_cnt;
  logic        be_err;
  logic        ovf_err;

  ft601_rx_ctrl_if bus();

  ft601_rx_ctrl #(.MAX_BURST(MAX_BURST)) dut (
    .ft601_clk   (clk),
    .reset_n     (reset_n),
    .en          (en),
    .err_clr     (err_clr),
    .bus         (bus.master),
    .rx_byte_cnt (rx_byte_cnt),
    .be_err      (be_err),
    .ovf_err     (ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus driver (sole writer of DUT inputs) ----------
  logic [35:0] hq[$];          // host-side words {be, data} waiting in the FT601
  bit   host_mode = 1'b1;
  logic cfg_en = 1'b0, cfg_gnt = 1'b0, cfg_af = 1'b0, cfg_full = 1'b0;
  logic cfg_clr = 1'b0, cfg_rst_n = 1'b0;
  logic rd_n_prev = 1'b1;
  logic [3:0] legal_be [4] = '{4'hF, 4'h7, 4'h3, 4'h1};

  initial begin
    bus.RXF_N = 1'b1; bus.DATA_IN = '0; bus.BE_IN = '0; bus.bus_gnt = 1'b0;
    bus.fifo_almost_full = 1'b0; bus.fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (host_mode) begin
        // The word on the pins was consumed if the DUT was reading at the
        // last rising edge and the FIFO showed data.
        if (!rd_n_prev && !bus.RXF_N && reset_n && hq.size() > 0) void'(hq.pop_front());
        bus.RXF_N = (hq.size() == 0);
        if (hq.size() > 0) {bus.BE_IN, bus.DATA_IN} = hq[0];
        else begin bus.DATA_IN = $urandom; bus.BE_IN = 4'($urandom_range(0, 15)); end
        en = cfg_en; bus.bus_gnt = cfg_gnt; bus.fifo_almost_full = cfg_af;
        bus.fifo_full = cfg_full; err_clr = cfg_clr; reset_n = cfg_rst_n;
      end else begin
        en = ($urandom_range(0, 9) != 0);
        bus.RXF_N = ($urandom_range(0, 3) == 0);
        bus.bus_gnt = ($urandom_range(0, 2) != 0);
        bus.fifo_almost_full = ($urandom_range(0, 7) == 0);
        bus.fifo_full = ($urandom_range(0, 15) == 0);
        err_clr = ($urandom_range(0, 31) == 0);
        bus.DATA_IN = $urandom;
        if ($urandom_range(0, 3) != 0) bus.BE_IN = legal_be[$urandom_range(0, 3)];
        else bus.BE_IN = 4'($urandom_range(0, 15));
        if (!reset_n) reset_n = 1'b1;
        else if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
      end
      rd_n_prev = bus.RD_N;
    end
  end

  // ---------------- behavioural model -------------------------------------
  logic        exp_oe_n, exp_rd_n, exp_req, exp_wr_en, exp_be_err, exp_ovf;
  logic [31:0] exp_data, exp_cnt;
  logic [3:0]  exp_be;
  logic        m_en, m_rxf, m_gnt, m_af, m_full, m_clr;
  logic [31:0] m_data;
  logic [3:0]  m_be;

  task automatic m_reset();
    exp_oe_n = 1'b1; exp_rd_n = 1'b1; exp_req = 1'b0; exp_wr_en = 1'b0;
    exp_data = '0; exp_be = '0; exp_cnt = '0; exp_be_err = 1'b0; exp_ovf = 1'b0;
  endtask

  // Wait for the next rising edge and latch the inputs seen there; a reset
  // assertion instead restores reset values and reports an abort.
  task automatic step(output bit ab);
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_reset();
      @(posedge reset_n);
      ab = 1'b1;
    end else begin
      m_en = en; m_rxf = bus.RXF_N; m_gnt = bus.bus_gnt; m_af = bus.fifo_almost_full;
      m_full = bus.fifo_full; m_clr = err_clr; m_data = bus.DATA_IN; m_be = bus.BE_IN;
      ab = 1'b0;
    end
  endtask

  // Per-edge datapath effect of capturing (or not) the word on the pins.
  task automatic m_edge(input bit cap);
    bit legal;
    legal = (m_be == 4'hF) || (m_be == 4'h7) || (m_be == 4'h3) || (m_be == 4'h1);
    exp_wr_en = 1'b0;
    if (cap && !m_full) begin
      exp_wr_en = 1'b1;
      exp_data  = m_data;
      exp_be    = m_be;
      exp_cnt   = exp_cnt + 32'($countones(m_be));
    end
    exp_be_err = (exp_be_err && !m_clr) || (cap && !legal);
    exp_ovf    = (exp_ovf && !m_clr) || (cap && m_full);
  endtask

  initial begin : model
    bit ab, cap, granted, dropped, done;
    int beats;
    m_reset();
    wait (reset_n === 1'b1);
    forever begin
      // idle: look for a reason to start a tenure
      step(ab); if (ab) continue;
      m_edge(1'b0);
      if (!(m_en && !m_rxf && !m_af)) continue;
      exp_req = 1'b1;
      // waiting for the grant; the host may withdraw its data meanwhile
      granted = 1'b0; dropped = 1'b0;
      while (!granted && !dropped && !ab) begin
        step(ab);
        if (!ab) begin
          m_edge(1'b0);
          if (m_rxf) dropped = 1'b1;
          else if (m_gnt) granted = 1'b1;
        end
      end
      if (ab) continue;
      if (dropped) begin exp_req = 1'b0; continue; end
      exp_oe_n = 1'b0;
      // one turnaround cycle with only OE asserted
      step(ab); if (ab) continue;
      m_edge(1'b0);
      exp_rd_n = 1'b0;
      // the read burst itself
      beats = 0; done = 1'b0;
      while (!done && !ab) begin
        step(ab);
        if (!ab) begin
          cap = !m_rxf;
          m_edge(cap);
          beats += int'(cap);
          if (m_rxf || m_af || beats == MAX_BURST) begin
            exp_oe_n = 1'b1; exp_rd_n = 1'b1; done = 1'b1;
          end
        end
      end
      if (ab) continue;
      // release cycle, bus still requested
      step(ab); if (ab) continue;
      m_edge(1'b0);
      exp_req = 1'b0;
    end
  end

  // ---------------- per-cycle compare + write log -------------------------
  logic [31:0] wr_log[$];
  logic [3:0]  be_log[$];
  int          req_rises = 0;
  logic        req_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("OE_N", bus.OE_N, exp_oe_n);
      chk("RD_N", bus.RD_N, exp_rd_n);
      chk("bus_req", bus.bus_req, exp_req);
      chk("fifo_wr_en", bus.fifo_wr_en, exp_wr_en);
      if (exp_wr_en) begin
        chk("fifo_wr_data", bus.fifo_wr_data, exp_data);
        chk("fifo_wr_be", bus.fifo_wr_be, exp_be);
      end
      chk("rx_byte_cnt", rx_byte_cnt, exp_cnt);
      chk("be_err", be_err, exp_be_err);
      chk("ovf_err", ovf_err, exp_ovf);
      if (bus.fifo_wr_en) begin wr_log.push_back(bus.fifo_wr_data); be_log.push_back(bus.fifo_wr_be); end
      if (bus.bus_req && !req_prev) req_rises++;
      req_prev = bus.bus_req;
    end
  end

  // ---------------- directed scenarios + random phase ---------------------
  task automatic wait_quiet(input string name, input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 3; i++) begin
      @(negedge clk);
      if (hq.size() == 0 && !bus.bus_req && !bus.fifo_wr_en) quiet++;
      else quiet = 0;
    end
    chk({name, "_settled"}, 32'(quiet >= 3), 32'd1);
  endtask

  initial begin : main
    int seen;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("rst_OE_N", bus.OE_N, 1); chk("rst_RD_N", bus.RD_N, 1);
    chk("rst_bus_req", bus.bus_req, 0); chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_wr_data", bus.fifo_wr_data, 0); chk("rst_wr_be", bus.fifo_wr_be, 0);
    chk("rst_cnt", rx_byte_cnt, 0); chk("rst_be_err", be_err, 0); chk("rst_ovf", ovf_err, 0);
    @(negedge clk); cfg_rst_n = 1'b1; cfg_en = 1'b1; cfg_gnt = 1'b1;
    repeat (2) @(negedge clk);

    // basic burst, including the minimum-tenure edge timing
    wr_log.delete(); be_log.delete();
    for (int i = 1; i <= 4; i++) hq.push_back({4'hF, 32'h1111_1111 * 32'(i)});
    @(posedge clk); #1; chk("e1_req", bus.bus_req, 1); chk("e1_oe_n", bus.OE_N, 1);
    @(posedge clk); #1; chk("e2_oe_n", bus.OE_N, 0); chk("e2_rd_n", bus.RD_N, 1);
    @(posedge clk); #1; chk("e3_rd_n", bus.RD_N, 0); chk("e3_wr_en", bus.fifo_wr_en, 0);
    @(posedge clk); #1; chk("e4_wr_en", bus.fifo_wr_en, 1); chk("e4_data", bus.fifo_wr_data, 32'h1111_1111);
    wait_quiet("basic", 60);
    chk("basic_words", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("basic_order", wr_log[i], 32'h1111_1111 * 32'(i + 1));
    chk("basic_cnt", rx_byte_cnt, 16);
    chk("basic_oe_n", bus.OE_N, 1); chk("basic_rd_n", bus.RD_N, 1); chk("basic_req", bus.bus_req, 0);

    // short final word, then an illegal BE pattern and its clear
    hq.push_back({4'hF, 32'hA0}); hq.push_back({4'hF, 32'hA1});
    hq.push_back({4'hF, 32'hA2}); hq.push_back({4'h3, 32'hA3});
    wait_quiet("short", 60);
    chk("short_cnt", rx_byte_cnt, 30); chk("short_be_err", be_err, 0);
    hq.push_back({4'h5, 32'hBAD});
    wait_quiet("illegal", 60);
    chk("illegal_cnt", rx_byte_cnt, 32); chk("illegal_be_err", be_err, 1);
    cfg_clr = 1'b1; @(negedge clk); cfg_clr = 1'b0; #2;
    chk("clr_be_err", be_err, 0);

    // almost-full backpressure after the third capture
    wr_log.delete();
    for (int i = 0; i < 10; i++) hq.push_back({4'hF, 32'hB000_0000 + 32'(i)});
    seen = 0;
    for (int i = 0; i < 60 && wr_log.size() < 3; i++) @(negedge clk);
    chk("bp_reached3", wr_log.size(), 3);
    cfg_af = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_words", wr_log.size(), 4); chk("bp_req_low", bus.bus_req, 0); chk("bp_oe_n", bus.OE_N, 1);
    cfg_af = 1'b0;
    wait_quiet("bp", 80);
    chk("bp_total", wr_log.size(), 10); chk("bp_cnt", rx_byte_cnt, 72);

    // grant withheld, then the host withdraws its data
    wr_log.delete(); cfg_gnt = 1'b0;
    for (int i = 0; i < 3; i++) hq.push_back({4'hF, 32'hC0 + 32'(i)});
    repeat (5) begin @(posedge clk); #1; chk("gw_req", bus.bus_req, 1); chk("gw_oe_n", bus.OE_N, 1); end
    @(negedge clk); hq.delete();
    @(posedge clk); #1; chk("gw_drop_req", bus.bus_req, 0);
    chk("gw_words", wr_log.size(), 0); chk("gw_cnt", rx_byte_cnt, 72);
    @(negedge clk); cfg_gnt = 1'b1;

    // burst limit of MAX_BURST words per tenure
    wr_log.delete(); req_rises = 0;
    for (int i = 0; i < 20; i++) hq.push_back({4'hF, 32'hD000_0000 + 32'(i)});
    wait_quiet("limit", 300);
    chk("limit_words", wr_log.size(), 20); chk("limit_cnt", rx_byte_cnt, 152);
    chk("limit_tenures", req_rises, 3);

    // overflow: words captured while full are dropped
    wr_log.delete(); cfg_full = 1'b1;
    hq.push_back({4'hF, 32'hE0}); hq.push_back({4'hF, 32'hE1});
    wait_quiet("ovf", 60);
    chk("ovf_words", wr_log.size(), 0); chk("ovf_err", ovf_err, 1); chk("ovf_cnt", rx_byte_cnt, 152);
    cfg_full = 1'b0;

    // asynchronous reset in the middle of a read burst
    for (int i = 0; i < 10; i++) hq.push_back({4'hF, 32'hF0 + 32'(i)});
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin @(negedge clk); if (bus.RD_N === 1'b0) seen = 1; end
    chk("rst_reached_read", seen, 1);
    cfg_rst_n = 1'b0; #2;
    chk("arst_OE_N", bus.OE_N, 1); chk("arst_RD_N", bus.RD_N, 1); chk("arst_req", bus.bus_req, 0);
    chk("arst_wr_en", bus.fifo_wr_en, 0); chk("arst_data", bus.fifo_wr_data, 0);
    chk("arst_cnt", rx_byte_cnt, 0); chk("arst_ovf", ovf_err, 0); chk("arst_be_err", be_err, 0);
    hq.delete();
    @(negedge clk); cfg_rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // randomized phase, checked cycle by cycle against the model
    host_mode = 1'b0;
    repeat (4000) @(negedge clk);
    host_mode = 1'b1; cfg_en = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
